// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit_pkg
//  Purpose  : Shared definitions for the fetch-stage program-counter unit.
//             Provides the FSM state encoding, the default reset vector and
//             the sequential fetch increment.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

  // Fetch controller states, explicitly encoded.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // first cycle out of reset, no request yet
    FETCH = 2'd1,  // request outstanding at the current PC
    PEND  = 2'd2   // redirect captured while memory was busy
  } state_t;

  localparam logic [31:0] c_resetVector = 32'h0000_0000;
  localparam int unsigned c_pcInc       = 4;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit_if
//  Purpose  : Bundles the control inputs and fetch outputs of the PC unit.
//  Ports    : master (PC unit side)
//               in : Stall, Taken, Jump, Target, IReady
//               out: PC, IReq, Flush, AddrErr
//             slave  (surrounding pipeline / instruction memory side)
//               mirror image of master
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_unit_if #(
  parameter int PC_WIDTH = 32
) ();

  logic                Stall;
  logic                Taken;
  logic                Jump;
  logic [PC_WIDTH-1:0] Target;
  logic                IReady;
  logic [PC_WIDTH-1:0] PC;
  logic                IReq;
  logic                Flush;
  logic                AddrErr;

  modport master (
    input  Stall, Taken, Jump, Target, IReady,
    output PC, IReq, Flush, AddrErr
  );

  modport slave (
    output Stall, Taken, Jump, Target, IReady,
    input  PC, IReq, Flush, AddrErr
  );

endinterface : pc_unit_if
`default_nettype wire

// File: rtl/pc_next.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next
//  Purpose  : Combinational next-PC selector. Chooses between hold,
//             sequential increment, the (aligned) redirect target and the
//             buffered pending target, and flags misaligned redirects.
//  Ports    : i_state         current controller state
//             i_pc            current fetch PC
//             i_pending       buffered redirect target
//             i_stall         hazard stall
//             i_taken/i_jump  redirect requests
//             i_target        raw redirect target
//             i_iReady        instruction memory accepts this cycle
//             o_nextPc        PC value for the next cycle
//             o_redirect      a redirect is requested this cycle
//             o_alignedTarget target with the low two bits cleared
//             o_addrErr       redirect target was misaligned
//  Revision : 1.0 - initial release
// ============================================================================
module pc_next
  import pc_unit_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  wire state_t              i_state,
  input  wire logic [PC_WIDTH-1:0] i_pc,
  input  wire logic [PC_WIDTH-1:0] i_pending,
  input  wire logic                i_stall,
  input  wire logic                i_taken,
  input  wire logic                i_jump,
  input  wire logic [PC_WIDTH-1:0] i_target,
  input  wire logic                i_iReady,
  output logic      [PC_WIDTH-1:0] o_nextPc,
  output logic                     o_redirect,
  output logic      [PC_WIDTH-1:0] o_alignedTarget,
  output logic                     o_addrErr
);

  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_alignedTarget;
  logic [PC_WIDTH-1:0] w_pcInc;

  assign w_redirect      = i_taken | i_jump;
  assign w_alignedTarget = {i_target[PC_WIDTH-1:2], 2'b00};
  // Increment wraps naturally at the top of the address space.
  assign w_pcInc         = i_pc + PC_WIDTH'(c_pcInc);

  assign o_redirect      = w_redirect;
  assign o_alignedTarget = w_alignedTarget;
  assign o_addrErr       = w_redirect & (i_target[1:0] != 2'b00);

  always_comb begin
    o_nextPc = i_pc;
    case (i_state)
      // No request is outstanding yet, so a redirect can land directly.
      IDLE: begin
        if (w_redirect) begin
          o_nextPc = w_alignedTarget;
        end
      end
      // Redirect beats stall; a redirect without IReady is parked in the
      // pending register by the parent, so the PC holds here.
      FETCH: begin
        if (w_redirect) begin
          if (i_iReady) begin
            o_nextPc = w_alignedTarget;
          end
        end else if (!i_stall && i_iReady) begin
          o_nextPc = w_pcInc;
        end
      end
      // A fresh redirect in the release cycle supersedes the buffered one.
      PEND: begin
        if (i_iReady) begin
          o_nextPc = w_redirect ? w_alignedTarget : i_pending;
        end
      end
      default: o_nextPc = i_pc;
    endcase
  end

endmodule : pc_next
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Fetch-stage program-counter controller. Holds the fetch PC,
//             issues instruction-memory requests, raises a one-cycle flush
//             on every redirect and buffers a redirect that arrives while
//             instruction memory is busy.
//  Ports    : CLK   rising-edge clock
//             nRST  synchronous active-low reset
//             bus   pc_unit_if.master
//                     in : Stall, Taken, Jump, Target, IReady
//                     out: PC, IReq, Flush, AddrErr (all registered)
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(c_resetVector)
) (
  input  wire logic  CLK,
  input  wire logic  nRST,
  pc_unit_if.master  bus
);

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_pending;
  logic                r_iReq;
  logic                r_flush;
  logic                r_addrErr;

  logic [PC_WIDTH-1:0] w_nextPc;
  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_alignedTarget;
  logic                w_addrErr;

  pc_next #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pcNext (
    .i_state         (r_state),
    .i_pc            (r_pc),
    .i_pending       (r_pending),
    .i_stall         (bus.Stall),
    .i_taken         (bus.Taken),
    .i_jump          (bus.Jump),
    .i_target        (bus.Target),
    .i_iReady        (bus.IReady),
    .o_nextPc        (w_nextPc),
    .o_redirect      (w_redirect),
    .o_alignedTarget (w_alignedTarget),
    .o_addrErr       (w_addrErr)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_pc      <= RESET_VECTOR;
      r_pending <= '0;
      r_iReq    <= 1'b0;
      r_flush   <= 1'b0;
      r_addrErr <= 1'b0;
    end else begin
      r_pc      <= w_nextPc;
      // Every redirect event, including one absorbed into PEND, kills the
      // younger instructions already in IF/ID and ID/EX.
      r_flush   <= w_redirect;
      r_addrErr <= w_addrErr;

      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_iReq  <= 1'b1;
        end

        FETCH: begin
          if (w_redirect && !bus.IReady) begin
            // Memory could not take the request: abandon it and remember
            // where to go once memory frees up.
            r_pending <= w_alignedTarget;
            r_state   <= PEND;
            r_iReq    <= 1'b0;
          end else begin
            r_state <= FETCH;
            r_iReq  <= 1'b1;
          end
        end

        PEND: begin
          if (bus.IReady) begin
            r_state <= FETCH;
            r_iReq  <= 1'b1;
          end else begin
            if (w_redirect) begin
              r_pending <= w_alignedTarget;
            end
            r_state <= PEND;
            r_iReq  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_iReq  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC      = r_pc;
  assign bus.IReq    = r_iReq;
  assign bus.Flush   = r_flush;
  assign bus.AddrErr = r_addrErr;

endmodule : pc_unit
`default_nettype wire
